// File: rtl/load_align_unit_pkg.sv
// Shared types and width helpers for the load alignment path.
// Sizes are log2(bytes); the FSM enum is shared with anything that probes the unit.
package load_align_unit_pkg;

  typedef enum logic [2:0] {
    MSIZE_B = 3'd0,
    MSIZE_H = 3'd1,
    MSIZE_W = 3'd2,
    MSIZE_D = 3'd3,
    MSIZE_Q = 3'd4
  } msize_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } ld_state_e;

  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int size_bits(input int data_w);
    return $clog2($clog2(data_w / 8) + 1);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero-extends the low (1<<size_i) bytes of data_i to DATA_W; pure combinational, no backpressure.
// A full-width size passes data_i through untouched.
module load_extend
  import load_align_unit_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]                     data_i,
  input  logic [$clog2($clog2(DATA_W/8)+1)-1:0] size_i,
  input  logic                                  unsigned_i,
  output logic [DATA_W-1:0]                     data_o
);

  localparam int OB = lane_bits(DATA_W);
  localparam int SW = size_bits(DATA_W);

  logic [DATA_W-1:0] keep;
  logic              sign;

  always_comb begin
    keep = {DATA_W{1'b1}};
    sign = 1'b0;
    for (int k = 0; k < OB; k++) begin
      if (size_i == SW'(k)) begin
        keep = ~({DATA_W{1'b1}} << (8 << k));
        sign = |(data_i & (DATA_W'(1) << ((8 << k) - 1)));
      end
    end
    data_o = (data_i & keep) | (~keep & {DATA_W{sign & ~unsigned_i}});
  end

endmodule

// File: rtl/load_align_unit.sv
// Load aligner: one or two aligned bus beats per request, result at t+2 (one beat) / t+3 (two) / t+1 (exception).
// Holds bus_addr until bus_data_ok and rsp_data until rsp_ready; LOAD_ALIGN_SPLIT_EN enables straddle splitting.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic [$clog2($clog2(DATA_W/8)+1)-1:0] req_size,
  input  logic                                  req_unsigned,
  output logic                                  bus_valid,
  output logic [ADDR_W-1:0]                     bus_addr,
  input  logic                                  bus_data_ok,
  input  logic [DATA_W-1:0]                     bus_data,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [DATA_W-1:0]                     rsp_data,
  output logic                                  rsp_exc
);

  localparam int B  = DATA_W / 8;
  localparam int OB = lane_bits(DATA_W);
  localparam int SW = size_bits(DATA_W);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [OB-1:0]     off_q;
  logic [SW-1:0]     size_q;
  logic              uns_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_exc_q;

  logic [OB-1:0]     off_d;
  logic [OB:0]       nbytes_d;
  logic              exc_d;
  logic              two_beat;
  logic [DATA_W-1:0] beat0_dat;
  logic [DATA_W-1:0] ext_in;
  logic [DATA_W-1:0] ext_out;

  assign off_d     = req_addr[OB-1:0];
  assign nbytes_d  = (OB+1)'(1) << req_size;
  // First beat is right-justified so its bytes land in the low result lanes.
  assign beat0_dat = bus_data >> {off_q, 3'b000};

`ifdef LOAD_ALIGN_SPLIT_EN
  logic              two_beat_q;
  logic [DATA_W-1:0] merge_q;
  logic              straddle_d;
  logic [OB:0]       hi_lanes;

  assign straddle_d = ({1'b0, off_d} + nbytes_d) > (OB+1)'(B);
  assign exc_d      = 1'b0;
  assign two_beat   = two_beat_q;
  assign hi_lanes   = (OB+1)'(B) - {1'b0, off_q};
  assign ext_in     = (state_q == ST_BEAT1) ? (merge_q | (bus_data << {hi_lanes, 3'b000}))
                                            : beat0_dat;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      two_beat_q <= 1'b0;
      merge_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && req_valid) two_beat_q <= straddle_d;
      if (state_q == ST_BEAT0 && bus_data_ok) merge_q <= beat0_dat;
    end
  end
`else
  // Without splitting, any access not naturally aligned to its size is refused.
  assign exc_d    = |(off_d & (nbytes_d[OB-1:0] - OB'(1)));
  assign two_beat = 1'b0;
  assign ext_in   = beat0_dat;
`endif

  load_extend #(
    .DATA_W(DATA_W)
  ) u_extend (
    .data_i    (ext_in),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_o    (ext_out)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      bus_addr_q <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_exc_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            bus_addr_q <= {req_addr[ADDR_W-1:OB], OB'(0)};
            off_q      <= off_d;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            rsp_exc_q  <= exc_d;
            if (exc_d) begin
              rsp_data_q <= '0;
              state_q    <= ST_RESP;
            end else begin
              state_q <= ST_BEAT0;
            end
          end
        end
        ST_BEAT0: begin
          if (bus_data_ok) begin
            if (two_beat) begin
              bus_addr_q <= bus_addr_q + ADDR_W'(B);
              state_q    <= ST_BEAT1;
            end else begin
              rsp_data_q <= ext_out;
              state_q    <= ST_RESP;
            end
          end
        end
`ifdef LOAD_ALIGN_SPLIT_EN
        ST_BEAT1: begin
          if (bus_data_ok) begin
            rsp_data_q <= ext_out;
            state_q    <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign bus_valid = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign bus_addr  = bus_addr_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_exc   = rsp_exc_q;

endmodule
